dcsk_tx_ctrl: RTL and testbench

//   DCSK transmitter controller, counterpart of the DCSK receiver FSM. Accepts parallel data

---
 rtl/dcsk_tx_ctrl.sv | 149 ++++++++++++++
 tb/tb_dcsk_tx_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcsk_tx_ctrl.sv
// DCSK transmitter controller: serialises words LSB first as reference/data chip pairs per bit.
// Optional DCSK_TX_MARK_EN adds the Tx_Ref / Tx_Word_End framing outputs.
module dcsk_tx_ctrl #(
   parameter int DATA_W = 8,
   parameter int MAX_SF = 16,
   parameter int ADDR_W = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DATA_W-1:0] Data_In,
   input  logic              Data_Valid,
   output logic              Data_Ready,
   input  logic [4:0]        Spread_Factor,
   input  logic              Chaos_Bit,
   output logic              Chaos_Req,
   output logic              Tx_Chip,
   output logic              Tx_Valid,
   output logic              Busy
`ifdef DCSK_TX_MARK_EN
   ,
   output logic              Tx_Ref,
   output logic              Tx_Word_End
`endif
);

   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   chip_cnt_q, chip_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [ADDR_W:0]     sf_q, sf_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [MAX_SF-1:0]   buf_q, buf_d;
   logic                tx_chip_q, tx_chip_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic                last_chip, last_bit, last_word_chip, accept;
`ifdef DCSK_TX_MARK_EN
   logic                tx_ref_q, tx_word_end_q;
`endif

   function automatic logic [ADDR_W:0] clamp_sf(input logic [4:0] sf);
      int v;
      v = int'(sf);
      if (v < 2) v = 2;
      else if (v > MAX_SF) v = MAX_SF;
      return v[ADDR_W:0];
   endfunction

   assign last_chip      = ({1'b0, chip_cnt_q} == (sf_q - 1'b1));
   assign last_bit       = (bit_cnt_q == BIT_W'(DATA_W - 1));
   assign last_word_chip = (state_q == DATA) && last_chip && last_bit;
   // Ready on the final data chip lets the next word follow with no idle chip.
   assign Data_Ready     = !Rst && ((state_q == IDLE) || last_word_chip);
   assign accept         = Data_Valid && Data_Ready;
   assign Chaos_Req      = !Rst && (state_q == REF);

   always_comb begin
      state_d    = state_q;
      chip_cnt_d = chip_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      sf_d       = sf_q;
      word_d     = word_q;
      buf_d      = buf_q;
      tx_chip_d  = 1'b0;
      tx_valid_d = 1'b0;
      case (state_q)
         IDLE: ;
         REF: begin
            tx_chip_d         = Chaos_Bit;
            tx_valid_d        = 1'b1;
            buf_d[chip_cnt_q] = Chaos_Bit;
            if (last_chip) begin
               chip_cnt_d = '0;
               state_d    = DATA;
            end else begin
               chip_cnt_d = chip_cnt_q + 1'b1;
            end
         end
         DATA: begin
            tx_chip_d  = buf_q[chip_cnt_q] ^ ~word_q[bit_cnt_q];
            tx_valid_d = 1'b1;
            if (last_chip) begin
               chip_cnt_d = '0;
               if (!last_bit) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  state_d   = REF;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               chip_cnt_d = chip_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         word_d     = Data_In;
         sf_d       = clamp_sf(Spread_Factor);
         bit_cnt_d  = '0;
         chip_cnt_d = '0;
         state_d    = REF;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= IDLE;
         chip_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         sf_q          <= '0;
         word_q        <= '0;
         buf_q         <= '0;
         tx_chip_q     <= 1'b0;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
`ifdef DCSK_TX_MARK_EN
         tx_ref_q      <= 1'b0;
         tx_word_end_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         chip_cnt_q    <= chip_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         sf_q          <= sf_d;
         word_q        <= word_d;
         buf_q         <= buf_d;
         tx_chip_q     <= tx_chip_d;
         tx_valid_q    <= tx_valid_d;
         busy_q        <= busy_d;
`ifdef DCSK_TX_MARK_EN
         tx_ref_q      <= (state_q == REF);
         tx_word_end_q <= last_word_chip;
`endif
      end
   end

   assign Tx_Chip  = tx_chip_q;
   assign Tx_Valid = tx_valid_q;
   assign Busy     = busy_q;
`ifdef DCSK_TX_MARK_EN
   assign Tx_Ref      = tx_ref_q;
   assign Tx_Word_End = tx_word_end_q;
`endif

endmodule

// File: tb/tb_dcsk_tx_ctrl.sv
// Randomised bench for dcsk_tx_ctrl against a per-word chip-list reference model.
module tb_dcsk_tx_ctrl;
   localparam int DW  = 8;
   localparam int MSF = 16;
   localparam int N   = 4096;

   logic       Clk = 1'b0;
   logic       Rst, Data_Valid, Data_Ready, Chaos_Bit, Chaos_Req, Tx_Chip, Tx_Valid, Busy;
   logic [7:0] Data_In;
   logic [4:0] Spread_Factor;
`ifdef DCSK_TX_MARK_EN
   logic       Tx_Ref, Tx_Word_End;
`endif

   always #5 Clk = ~Clk;

   dcsk_tx_ctrl #(.DATA_W(DW), .MAX_SF(MSF), .ADDR_W(4)) dut (
      .Clk(Clk), .Rst(Rst), .Data_In(Data_In), .Data_Valid(Data_Valid),
      .Data_Ready(Data_Ready), .Spread_Factor(Spread_Factor), .Chaos_Bit(Chaos_Bit),
      .Chaos_Req(Chaos_Req), .Tx_Chip(Tx_Chip), .Tx_Valid(Tx_Valid), .Busy(Busy)
`ifdef DCSK_TX_MARK_EN
      , .Tx_Ref(Tx_Ref), .Tx_Word_End(Tx_Word_End)
`endif
   );

   typedef struct packed {logic chip; logic rf; logic last;} ent_t;

   ent_t stateq[$];
   ent_t pend;
   logic pend_v;
   logic stream [N];
   int   cidx, mptr;
   int   n_cmp, n_mis;
   bit   chk_on;
   int   tx_cnt, req_cnt, tx_runs, mid_hs, wend_cnt;
   logic prev_tx;
   logic txlog[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Whole-word expectation: per bit, SF reference chips from the chaos stream then SF data chips.
   task automatic push_word(input logic [7:0] d, input logic [4:0] sf);
      int   s;
      logic r [MSF];
      s = (sf < 2) ? 2 : ((sf > MSF) ? MSF : int'(sf));
      for (int b = 0; b < DW; b++) begin
         for (int k = 0; k < s; k++) begin
            r[k] = stream[mptr % N];
            mptr++;
            stateq.push_back('{chip: r[k], rf: 1'b1, last: 1'b0});
         end
         for (int k = 0; k < s; k++)
            stateq.push_back('{chip: d[b] ? r[k] : !r[k], rf: 1'b0,
                               last: (b == DW - 1) && (k == s - 1)});
      end
   endtask

   task automatic set_stream(input bit pattern);
      logic [3:0] pat;
      pat = 4'b1101;
      for (int i = 0; i < N; i++)
         stream[i] = pattern ? pat[i % 4] : 1'($urandom_range(0, 1));
      cidx = 0;
      mptr = 0;
      Chaos_Bit = stream[0];
   endtask

   task automatic clr();
      tx_cnt = 0; req_cnt = 0; tx_runs = 0; mid_hs = 0; wend_cnt = 0;
      txlog.delete();
   endtask

   // One clock: called at a falling edge, returns at the next falling edge.
   task automatic step(input logic rst, input logic vld, input logic [7:0] d,
                       input logic [4:0] sf, output logic acc);
      logic req, exp_rdy;
      if (chk_on) begin
         check("tx_valid", Tx_Valid, pend_v);
         check("tx_chip", Tx_Chip, pend_v ? pend.chip : 1'b0);
`ifdef DCSK_TX_MARK_EN
         check("tx_ref", Tx_Ref, pend_v & pend.rf);
         check("tx_word_end", Tx_Word_End, pend_v & pend.last);
`endif
      end
      if (Tx_Valid === 1'b1) begin
         tx_cnt++;
         txlog.push_back(Tx_Chip);
         if (!prev_tx) tx_runs++;
      end
      prev_tx = (Tx_Valid === 1'b1);
`ifdef DCSK_TX_MARK_EN
      if (Tx_Word_End === 1'b1) wend_cnt++;
`endif
      Rst = rst; Data_Valid = vld; Data_In = d; Spread_Factor = sf;
      #1;
      if (chk_on) begin
         check("busy", Busy, stateq.size() != 0);
         check("chaos_req", Chaos_Req, !rst && stateq.size() != 0 && stateq[0].rf);
      end
      if (stateq.size() != 0) begin
         pend = stateq.pop_front();
         pend_v = 1'b1;
      end else begin
         pend_v = 1'b0;
      end
      exp_rdy = !rst && stateq.size() == 0;
      if (chk_on) check("data_ready", Data_Ready, exp_rdy);
      if (Chaos_Req === 1'b1) req_cnt++;
      if (Data_Ready === 1'b1 && Busy === 1'b1 && vld) mid_hs++;
      req = Chaos_Req;
      acc = vld && exp_rdy;
      if (rst) begin
         stateq.delete();
         pend_v = 1'b0;
      end else if (acc) begin
         push_word(d, sf);
      end
      @(posedge Clk);
      #1;
      if (req === 1'b1) begin
         cidx++;
         Chaos_Bit = stream[cidx % N];
      end
      if (rst) mptr = cidx;
      @(negedge Clk);
   endtask

   task automatic run_idle();
      int   n;
      logic a;
      n = 0;
      while ((stateq.size() != 0 || pend_v) && n < 3000) begin
         step(1'b0, 1'b0, 8'h00, 5'd0, a);
         n++;
      end
      check("drain_bound", n < 3000, 1'b1);
   endtask

   initial begin
      logic       a;
      logic [7:0] v0, v1, w;
      int         wi, n;
      n_cmp = 0; n_mis = 0; chk_on = 0; pend_v = 1'b0; prev_tx = 1'b0;
      Rst = 1'b1; Data_Valid = 1'b1; Data_In = 8'h55; Spread_Factor = 5'd4;
      set_stream(1'b0);
      clr();
      @(negedge Clk);

      // reset held two cycles with Data_Valid high
      step(1'b1, 1'b1, 8'h55, 5'd4, a);
      chk_on = 1;
      step(1'b1, 1'b1, 8'h55, 5'd4, a);
      step(1'b0, 1'b0, 8'h00, 5'd4, a);

      // SF=4 with repeating chaos 1,0,1,1 and word 8'h01
      set_stream(1'b1);
      clr();
      step(1'b0, 1'b1, 8'h01, 5'd4, a);
      run_idle();
      check("t2_tx_cnt", tx_cnt, 64);
      check("t2_req_cnt", req_cnt, 32);
      check("t2_tx_runs", tx_runs, 1);
      v0 = '0; v1 = '0;
      for (int i = 0; i < 8; i++) begin
         v0 = {v0[6:0], txlog[i]};
         v1 = {v1[6:0], txlog[8 + i]};
      end
      check("t2_bit0_chips", v0, 8'b1011_1011);
      check("t2_bit1_chips", v1, 8'b1011_0100);

      // back-to-back words, SF=2
      set_stream(1'b0);
      clr();
      wi = 0; n = 0;
      while (wi < 2 && n < 500) begin
         step(1'b0, 1'b1, (wi == 0) ? 8'hA5 : 8'h3C, 5'd2, a);
         if (a) wi++;
         n++;
      end
      run_idle();
      check("t3_tx_cnt", tx_cnt, 64);
      check("t3_tx_runs", tx_runs, 1);
      check("t3_boundary_handshakes", mid_hs, 1);

      // SF clamping
      clr();
      step(1'b0, 1'b1, 8'($urandom), 5'd0, a);
      run_idle();
      check("t4_sf0_cnt", tx_cnt, 32);
      clr();
      step(1'b0, 1'b1, 8'($urandom), 5'd20, a);
      run_idle();
      check("t4_sf20_cnt", tx_cnt, 256);

      // reset at chip 5 of bit 3, then a fresh word
      clr();
      step(1'b0, 1'b1, 8'h5A, 5'd4, a);
      repeat (29) step(1'b0, 1'b0, 8'h00, 5'd4, a);
      step(1'b1, 1'b0, 8'h00, 5'd4, a);
      step(1'b0, 1'b0, 8'h00, 5'd4, a);
      check("t5_idle_after_rst", Tx_Valid, 1'b0);
      clr();
      step(1'b0, 1'b1, 8'hFF, 5'd4, a);
      run_idle();
      check("t5_restart_cnt", tx_cnt, 64);

      // SF=3, all-zero word
      clr();
      step(1'b0, 1'b1, 8'h00, 5'd3, a);
      run_idle();
      check("t6_tx_cnt", tx_cnt, 48);
`ifdef DCSK_TX_MARK_EN
      check("t6_word_end_cnt", wend_cnt, 1);
`endif

      // random traffic: valid gaps, held words, SF jitter mid-word, rare resets
      set_stream(1'b0);
      clr();
      w = 8'($urandom);
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), w,
              5'($urandom_range(0, 31)), a);
         if (a) w = 8'($urandom);
      end
      run_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
